w_reg_pe_param: RTL and testbench

//  Parametrised weight-register PE for the conv array.

---
 rtl/w_pe_pkg.sv | 20 ++
 rtl/count_n.sv | 35 +++
 rtl/w_reg_pe_param.sv | 124 ++++++++++++
 tb/tb_w_reg_pe_param.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/w_pe_pkg.sv
// Shared types and helpers for the weight-register PE: forwarding directions,
// FSM states and the kernel tap index used as ROM address.
package w_pe_pkg;

   localparam logic [1:0] DIR_NONE  = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_HOME  = 2'd3;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   function automatic int unsigned tap_idx(input int unsigned x, input int unsigned y,
                                           input int unsigned k);
      return y * k + x;
   endfunction

endpackage

// File: rtl/count_n.sv
// Modulo-MAX counter with an enable; carry marks the enabled cycle that wraps,
// so instances chain directly into the next counter's enable.
module count_n #(
   parameter  int MAX = 3,
   localparam int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
   input  logic         clk,
   input  logic         xrst,
   input  logic         en,
   output logic [W-1:0] q,
   output logic         carry
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign q     = cnt_q;
   assign carry = en & (cnt_q == W'(MAX - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = carry ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (xrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/w_reg_pe_param.sv
// Weight-register PE: holds NCH weights for the current kernel tap, walks the
// kernel/map counters and sources weights from the ROM on map (0,0), else the chain.
module w_reg_pe_param
   import w_pe_pkg::*;
#(
   parameter  int NCH = 16,
   parameter  int DW  = 8,
   parameter  int K   = 3,
   parameter  int M   = 19,
   localparam int AW  = $clog2(K * K),
   localparam int KW  = (K > 1) ? $clog2(K) : 1,
   localparam int MW  = (M > 1) ? $clog2(M) : 1
) (
   input  logic              clk,
   input  logic              xrst,
   input  logic              start,
   input  logic              en,
   output logic [AW-1:0]     raddr,
   input  logic [NCH*DW-1:0] rdata,
   input  logic [NCH*DW-1:0] w_in,
   input  logic              w_in_valid,
   output logic [NCH*DW-1:0] w_q,
   output logic              w_q_valid,
   output logic [1:0]        fwd_dir,
   output logic [KW-1:0]     x_q,
   output logic [KW-1:0]     y_q,
   output logic [MW-1:0]     X_q,
   output logic [MW-1:0]     Y_q,
   output logic              busy,
   output logic              finish
);

   state_e            state_q, state_d;
   logic [NCH*DW-1:0] w_d;
   logic              finish_q, finish_d;
   logic              run, step, src_is_rom;
   logic              xWrap, yWrap, XWrap, YWrap;
   logic              xCarry, yCarry, XCarry, YCarry;
   logic [KW-1:0]     xNext, yNext;
   logic [MW-1:0]     XNext, YNext;

   assign run   = (state_q == S_RUN);
   assign xWrap = (x_q == KW'(K - 1));
   assign yWrap = (y_q == KW'(K - 1));
   assign XWrap = (X_q == MW'(M - 1));
   assign YWrap = (Y_q == MW'(M - 1));

   // Position after an unconditional advance; it does not depend on step, so
   // raddr and the weight source stay stable while the PE is stalled.
   always_comb begin
      xNext = xWrap ? '0 : x_q + 1'b1;
      yNext = y_q;
      XNext = X_q;
      YNext = Y_q;
      if (xWrap) begin
         yNext = yWrap ? '0 : y_q + 1'b1;
      end
      if (xWrap & yWrap) begin
         XNext = XWrap ? '0 : X_q + 1'b1;
      end
      if (xWrap & yWrap & XWrap) begin
         YNext = YWrap ? '0 : Y_q + 1'b1;
      end
   end

   assign src_is_rom = (XNext == '0) && (YNext == '0);
   assign step       = run & en & (src_is_rom | w_in_valid);
   assign raddr      = run ? AW'(tap_idx(32'(xNext), 32'(yNext), K)) : '0;

   count_n #(.MAX(K)) uCountX (.clk(clk), .xrst(xrst), .en(step),   .q(x_q), .carry(xCarry));
   count_n #(.MAX(K)) uCountY (.clk(clk), .xrst(xrst), .en(xCarry), .q(y_q), .carry(yCarry));
   count_n #(.MAX(M)) uCountMX(.clk(clk), .xrst(xrst), .en(yCarry), .q(X_q), .carry(XCarry));
   count_n #(.MAX(M)) uCountMY(.clk(clk), .xrst(xrst), .en(XCarry), .q(Y_q), .carry(YCarry));

   always_comb begin
      state_d  = state_q;
      w_d      = w_q;
      finish_d = 1'b0;
      fwd_dir  = DIR_NONE;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               w_d     = rdata;
            end
         end
         S_RUN: begin
            if (step) begin
               w_d = src_is_rom ? rdata : w_in;
               if (xWrap & XWrap) begin
                  fwd_dir = DIR_HOME;
               end else if (xWrap) begin
                  fwd_dir = DIR_DOWN;
               end else begin
                  fwd_dir = DIR_RIGHT;
               end
               // Carry out of the map-row counter is the final step of the frame.
               if (YCarry) begin
                  state_d  = S_IDLE;
                  finish_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (xrst) begin
         state_q  <= S_IDLE;
         w_q      <= '0;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         w_q      <= w_d;
         finish_q <= finish_d;
      end
   end

   assign w_q_valid = run;
   assign busy      = (state_q != S_IDLE);
   assign finish    = finish_q;

endmodule

// File: tb/tb_w_reg_pe_param.sv
// Scoreboard bench for w_reg_pe_param: a full 3x3/19x19 frame with stalls and a
// mid-frame reset, plus a small 2x2/2x2 instance with a toggling enable.
module tb_w_reg_pe_param;
   import w_pe_pkg::*;

   localparam int KA = 3, MA = 19, NA = 16, DA = 8;
   localparam int KB = 2, MB = 2, NB = 2, DB = 4;

   typedef struct {
      logic [127:0] w;
      int           x;
      int           y;
      int           bx;
      int           by;
      logic         busy;
      logic         fin;
   } expT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int   vectors     = 0;
   int   miscompares = 0;
   int   finIdx;
   logic lastFin;
   expT  sbqA[$];
   expT  sbqB[$];

   logic               xrstA, startA, enA, wvA;
   logic [NA*DA-1:0]   rdataA, winA, wqA;
   logic [3:0]         raddrA;
   logic               wqvA, busyA, finA;
   logic [1:0]         dirA, xA, yA;
   logic [4:0]         bxA, byA;
   logic [127:0]       romA;

   logic               xrstB, startB, enB, wvB;
   logic [NB*DB-1:0]   rdataB, winB, wqB;
   logic [1:0]         raddrB;
   logic               wqvB, busyB, finB;
   logic [1:0]         dirB;
   logic [0:0]         xB, yB, bxB, byB;
   logic [127:0]       romB;

   w_reg_pe_param #(.NCH(NA), .DW(DA), .K(KA), .M(MA)) dutA (
      .clk(clk), .xrst(xrstA), .start(startA), .en(enA), .raddr(raddrA), .rdata(rdataA),
      .w_in(winA), .w_in_valid(wvA), .w_q(wqA), .w_q_valid(wqvA), .fwd_dir(dirA),
      .x_q(xA), .y_q(yA), .X_q(bxA), .Y_q(byA), .busy(busyA), .finish(finA));

   w_reg_pe_param #(.NCH(NB), .DW(DB), .K(KB), .M(MB)) dutB (
      .clk(clk), .xrst(xrstB), .start(startB), .en(enB), .raddr(raddrB), .rdata(rdataB),
      .w_in(winB), .w_in_valid(wvB), .w_q(wqB), .w_q_valid(wqvB), .fwd_dir(dirB),
      .x_q(xB), .y_q(yB), .X_q(bxB), .Y_q(byB), .busy(busyB), .finish(finB));

   // Weight ROM: every tap and channel holds a distinct value.
   function automatic logic [127:0] romWord(input int tap, input int nch, input int dw);
      logic [127:0] r;
      int           v;
      r = '0;
      for (int c = 0; c < nch; c++) begin
         v = tap * 37 + c * 11 + 5;
         for (int b = 0; b < dw; b++) r[c*dw+b] = v[b];
      end
      return r;
   endfunction

   always_comb romA = romWord(int'(raddrA), NA, DA);
   always_comb romB = romWord(int'(raddrB), NB, DB);
   assign rdataA = romA[NA*DA-1:0];
   assign rdataB = romB[NB*DB-1:0];

   function automatic expT resetExp();
      expT r;
      r.w = '0; r.x = 0; r.y = 0; r.bx = 0; r.by = 0; r.busy = 1'b0; r.fin = 1'b0;
      return r;
   endfunction

   task automatic nextPos(input expT e, input int k, input int m,
                          output int nx, output int ny, output int nbx, output int nby);
      nx  = (e.x == k - 1) ? 0 : e.x + 1;
      ny  = e.y;
      nbx = e.bx;
      nby = e.by;
      if (e.x == k - 1) ny = (e.y == k - 1) ? 0 : e.y + 1;
      if (e.x == k - 1 && e.y == k - 1) nbx = (e.bx == m - 1) ? 0 : e.bx + 1;
      if (e.x == k - 1 && e.y == k - 1 && e.bx == m - 1) nby = (e.by == m - 1) ? 0 : e.by + 1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One cycle on DUT d: drive inputs at negedge, compare against the expectation
   // queued last cycle, then queue the expectation for the following cycle.
   task automatic applyStimulus(input int d, input logic enV, input logic vV,
                                input logic stV, input logic rsV);
      expT          e, n;
      int           k, m, nch, dw, nx, ny, nbx, nby, expAddr;
      logic         srcRom, st;
      logic [1:0]   expDir;
      logic [127:0] winV, msk;
      logic [127:0] oW, oAddr, oDir, oX, oY, oBX, oBY, oV, oBusy, oFin;
      k   = (d == 0) ? KA : KB;
      m   = (d == 0) ? MA : MB;
      nch = (d == 0) ? NA : NB;
      dw  = (d == 0) ? DA : DB;
      msk = (nch * dw >= 128) ? '1 : ((128'd1 << (nch * dw)) - 128'd1);
      @(negedge clk);
      winV = {$urandom, $urandom, $urandom, $urandom} & msk;
      if (d == 0) begin
         xrstA = rsV; startA = stV; enA = enV; wvA = vV; winA = winV;
      end else begin
         xrstB = rsV; startB = stV; enB = enV; wvB = vV; winB = winV[NB*DB-1:0];
      end
      #1;
      if (d == 0) begin
         e = (sbqA.size() > 0) ? sbqA.pop_front() : resetExp();
         oW = 128'(wqA); oAddr = 128'(raddrA); oDir = 128'(dirA); oX = 128'(xA); oY = 128'(yA);
         oBX = 128'(bxA); oBY = 128'(byA); oV = 128'(wqvA); oBusy = 128'(busyA); oFin = 128'(finA);
      end else begin
         e = (sbqB.size() > 0) ? sbqB.pop_front() : resetExp();
         oW = 128'(wqB); oAddr = 128'(raddrB); oDir = 128'(dirB); oX = 128'(xB); oY = 128'(yB);
         oBX = 128'(bxB); oBY = 128'(byB); oV = 128'(wqvB); oBusy = 128'(busyB); oFin = 128'(finB);
      end
      nextPos(e, k, m, nx, ny, nbx, nby);
      srcRom  = (nbx == 0 && nby == 0);
      st      = e.busy && enV && (srcRom || vV);
      expAddr = e.busy ? ny * k + nx : 0;
      expDir  = DIR_NONE;
      if (st) begin
         if (e.x == k - 1 && e.bx == m - 1) expDir = DIR_HOME;
         else if (e.x == k - 1)             expDir = DIR_DOWN;
         else                               expDir = DIR_RIGHT;
      end
      checkOutput("w_q", oW, e.w);
      checkOutput("x_q", oX, 128'(e.x));
      checkOutput("y_q", oY, 128'(e.y));
      checkOutput("X_q", oBX, 128'(e.bx));
      checkOutput("Y_q", oBY, 128'(e.by));
      checkOutput("w_q_valid", oV, 128'(e.busy));
      checkOutput("busy", oBusy, 128'(e.busy));
      checkOutput("finish", oFin, 128'(e.fin));
      checkOutput("raddr", oAddr, 128'(expAddr));
      checkOutput("fwd_dir", oDir, 128'(expDir));
      lastFin = oFin[0];
      n     = e;
      n.fin = 1'b0;
      if (rsV) begin
         n = resetExp();
      end else if (!e.busy) begin
         if (stV) begin
            n.busy = 1'b1;
            n.w    = romWord(0, nch, dw);
         end
      end else if (st) begin
         n.x = nx; n.y = ny; n.bx = nbx; n.by = nby;
         n.w = srcRom ? romWord(ny * k + nx, nch, dw) : winV;
         if (srcRom && nx == 0 && ny == 0) begin
            n.busy = 1'b0;
            n.fin  = 1'b1;
         end
      end
      if (d == 0) sbqA.push_back(n);
      else        sbqB.push_back(n);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      xrstA = 1'b1; startA = 1'b0; enA = 1'b0; wvA = 1'b0; winA = '0;
      xrstB = 1'b1; startB = 1'b0; enB = 1'b0; wvB = 1'b0; winB = '0;
      repeat (3) @(posedge clk);
      sbqA.push_back(resetExp());
      sbqB.push_back(resetExp());

      // Reset state, then start together with reset (reset wins).
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Full unstalled frame; finish must appear 3249 cycles after RUN entry.
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0);
      finIdx = -1;
      for (int i = 0; i < 3260 && finIdx < 0; i++) begin
         applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
         if (lastFin) finIdx = i;
      end
      checkOutput("finishLatencyA", 128'(finIdx), 128'(KA * KA * MA * MA));
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Second frame: chain stalls at X=1, enable stalls, random stalls, stray start.
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < KA * KA; i++) applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++)
         applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      for (int i = 0; i < 200 && bxA != 5'd5; i++) applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Mid-frame reset at X=5: IDLE with no finish, then a clean restart.
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Small instance with enable toggling: 16 steps over 32 cycles.
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b0);
      finIdx = -1;
      for (int i = 0; i < 40 && finIdx < 0; i++) begin
         applyStimulus(1, (i % 2) == 0, 1'b1, 1'b0, 1'b0);
         if (lastFin) finIdx = i;
      end
      checkOutput("finishLatencyB", 128'(finIdx), 128'(31));
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
